// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage F/D/E/M1/M2/WB pipeline: load-use interlock,
// data-memory freeze, branch/mret redirect and interrupt entry via a drain of E/M1/M2.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic             e_valid,
    input  logic             e_is_load,
    input  logic [4:0]       e_rd,
    input  logic             e_br_taken,
    input  logic             e_mret,
    input  logic             m1_valid,
    input  logic             m1_is_load,
    input  logic [4:0]       m1_rd,
    input  logic             m1_mem_req,
    input  logic             dmem_ready,
    input  logic             m2_valid,
    input  logic             irq_req,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             stall_em1,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em1,
    output logic             flush_m1m2,
    output logic [1:0]       pc_sel,
    output logic             irq_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_TRAP = 2'd2;
    localparam logic [1:0] PC_EPC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_TRAP_JMP
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   perf_q, perf_d;

    logic       freeze;
    logic       load_use;
    logic       pipe_empty;
    logic       stall_pc_c, stall_fd_c, stall_de_c, stall_em1_c;
    logic       flush_fd_c, flush_de_c, flush_em1_c, flush_m1m2_c;
    logic [1:0] pc_sel_c;
    logic       irq_ack_c;
    logic       mem_timeout_c;

    function automatic logic hit(input logic [4:0] r);
        return (e_valid  && e_is_load  && (e_rd  == r)) ||
               (m1_valid && m1_is_load && (m1_rd == r));
    endfunction

    assign freeze     = m1_mem_req && !dmem_ready;
    assign load_use   = (d_use_rs1 && (d_rs1 != 5'd0) && hit(d_rs1)) ||
                        (d_use_rs2 && (d_rs2 != 5'd0) && hit(d_rs2));
    assign pipe_empty = !(e_valid || m1_valid || m2_valid);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        stall_pc_c   = 1'b0;
        stall_fd_c   = 1'b0;
        stall_de_c   = 1'b0;
        stall_em1_c  = 1'b0;
        flush_fd_c   = 1'b0;
        flush_de_c   = 1'b0;
        flush_em1_c  = 1'b0;
        flush_m1m2_c = 1'b0;
        pc_sel_c     = PC_SEQ;
        irq_ack_c    = 1'b0;

        if (freeze) begin
            // Hold everything up to M1; M2 advances and gets a bubble behind it.
            stall_pc_c   = 1'b1;
            stall_fd_c   = 1'b1;
            stall_de_c   = 1'b1;
            stall_em1_c  = 1'b1;
            flush_m1m2_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (e_br_taken || e_mret) begin
                        flush_fd_c = 1'b1;
                        flush_de_c = 1'b1;
                        pc_sel_c   = e_br_taken ? PC_BR : PC_EPC;
                    end else if (irq_req) begin
                        stall_pc_c = 1'b1;
                        stall_fd_c = 1'b1;
                        flush_de_c = 1'b1;
                        state_d    = ST_DRAIN;
                    end else if (load_use) begin
                        stall_pc_c = 1'b1;
                        stall_fd_c = 1'b1;
                        flush_de_c = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    stall_pc_c = 1'b1;
                    stall_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    if (pipe_empty) state_d = ST_TRAP_JMP;
                end
                ST_TRAP_JMP: begin
                    pc_sel_c   = PC_TRAP;
                    irq_ack_c  = 1'b1;
                    flush_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    state_d    = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        mem_timeout_c = freeze && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

        perf_d = perf_q;
        if (stall_pc_c && (perf_q != {CNT_W{1'b1}})) perf_d = perf_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            perf_q     <= perf_d;
        end
    end

    // Outputs are forced low while reset is held, independent of the inputs.
    assign stall_pc       = nrst && stall_pc_c;
    assign stall_fd       = nrst && stall_fd_c;
    assign stall_de       = nrst && stall_de_c;
    assign stall_em1      = nrst && stall_em1_c;
    assign flush_fd       = nrst && flush_fd_c;
    assign flush_de       = nrst && flush_de_c;
    assign flush_em1      = nrst && flush_em1_c;
    assign flush_m1m2     = nrst && flush_m1m2_c;
    assign pc_sel         = nrst ? pc_sel_c : PC_SEQ;
    assign irq_ack        = nrst && irq_ack_c;
    assign mem_timeout    = nrst && mem_timeout_c;
    assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control vectors for load-use,
// memory freeze/timeout, redirects, interrupt drain and asynchronous reset.
module tb_pipe_hazard_ctrl;

    logic        clk, nrst;
    logic [4:0]  d_rs1, d_rs2, e_rd, m1_rd;
    logic        d_use_rs1, d_use_rs2, e_valid, e_is_load, e_br_taken, e_mret;
    logic        m1_valid, m1_is_load, m1_mem_req, dmem_ready, m2_valid, irq_req;
    logic        stall_pc, stall_fd, stall_de, stall_em1;
    logic        flush_fd, flush_de, flush_em1, flush_m1m2;
    logic [1:0]  pc_sel;
    logic        irq_ack, mem_timeout;
    logic [31:0] perf_stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Output bundle: {stall_pc,stall_fd,stall_de,stall_em1,flush_fd,flush_de,flush_em1,flush_m1m2,pc_sel,irq_ack,mem_timeout}
    logic [11:0] outs;
    assign outs = {stall_pc, stall_fd, stall_de, stall_em1, flush_fd, flush_de,
                   flush_em1, flush_m1m2, pc_sel, irq_ack, mem_timeout};

    localparam logic [11:0] O_IDLE = 12'h000;
    localparam logic [11:0] O_LU   = 12'hC40;
    localparam logic [11:0] O_FRZ  = 12'hF10;
    localparam logic [11:0] O_FRZT = 12'hF11;
    localparam logic [11:0] O_BR   = 12'h0C4;
    localparam logic [11:0] O_MRET = 12'h0CC;
    localparam logic [11:0] O_TRAP = 12'h0CA;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(2), .CNT_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_valid(e_valid), .e_is_load(e_is_load), .e_rd(e_rd),
        .e_br_taken(e_br_taken), .e_mret(e_mret),
        .m1_valid(m1_valid), .m1_is_load(m1_is_load), .m1_rd(m1_rd),
        .m1_mem_req(m1_mem_req), .dmem_ready(dmem_ready), .m2_valid(m2_valid),
        .irq_req(irq_req),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_de(stall_de), .stall_em1(stall_em1),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em1(flush_em1), .flush_m1m2(flush_m1m2),
        .pc_sel(pc_sel), .irq_ack(irq_ack), .mem_timeout(mem_timeout),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        d_rs1 = 5'd0; d_rs2 = 5'd0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        e_valid = 1'b0; e_is_load = 1'b0; e_rd = 5'd0; e_br_taken = 1'b0; e_mret = 1'b0;
        m1_valid = 1'b0; m1_is_load = 1'b0; m1_rd = 5'd0; m1_mem_req = 1'b0;
        dmem_ready = 1'b1; m2_valid = 1'b0; irq_req = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [11:0] exp);
        #1;
        check(tag, 32'(outs), 32'(exp));
    endtask

    initial begin
        clr();
        nrst = 1'b0;
        m1_mem_req = 1'b1; dmem_ready = 1'b0; irq_req = 1'b1;
        chk_outs("reset_outs", O_IDLE);
        check("reset_perf", perf_stall_cnt, 32'd0);
        #10;
        clr();
        nrst = 1'b1;
        tick();

        // T1: load-use interlock
        e_valid = 1; e_is_load = 1; e_rd = 5'd5; d_rs1 = 5'd5; d_use_rs1 = 1;
        chk_outs("lu_e_stage", O_LU);
        tick();
        e_valid = 0; e_is_load = 0; m1_valid = 1; m1_is_load = 1; m1_rd = 5'd5;
        chk_outs("lu_m1_stage", O_LU);
        tick();
        m1_valid = 0; m1_is_load = 0;
        chk_outs("lu_cleared", O_IDLE);
        e_valid = 1; e_is_load = 1; e_rd = 5'd0; d_rs1 = 5'd0;
        chk_outs("lu_x0_ignored", O_IDLE);
        clr();
        d_rs1 = 5'd3; d_use_rs1 = 0; e_valid = 1; e_is_load = 1; e_rd = 5'd3;
        chk_outs("lu_no_use", O_IDLE);
        clr();
        d_rs2 = 5'd7; d_use_rs2 = 1; m1_valid = 1; m1_is_load = 1; m1_rd = 5'd7;
        chk_outs("lu_rs2_m1", O_LU);
        tick();
        clr();
        chk_outs("idle_after_lu", O_IDLE);
        check("perf_after_t1", perf_stall_cnt, 32'd3);

        // T2: memory freeze and timeout (MEM_TIMEOUT=2)
        m1_mem_req = 1; dmem_ready = 0;
        chk_outs("frz_c1", O_FRZ);
        tick();
        chk_outs("frz_c2_timeout", O_FRZT);
        tick();
        e_br_taken = 1;
        chk_outs("frz_c3_dominates_br", O_FRZ);
        tick();
        e_br_taken = 0; dmem_ready = 1;
        chk_outs("frz_released", O_IDLE);
        tick();
        dmem_ready = 0;
        chk_outs("frz2_c1", O_FRZ);
        tick();
        chk_outs("frz2_c2_timeout", O_FRZT);
        tick();
        clr();
        chk_outs("frz2_released", O_IDLE);
        check("perf_after_t2", perf_stall_cnt, 32'd8);

        // T3: redirects and branch-over-irq priority
        e_mret = 1;
        chk_outs("mret", O_MRET);
        e_br_taken = 1;
        chk_outs("br_beats_mret", O_BR);
        e_mret = 0; irq_req = 1;
        chk_outs("br_beats_irq", O_BR);
        tick();
        e_br_taken = 0;
        chk_outs("irq_enter_drain", O_LU);
        tick();
        chk_outs("drain_empty", O_LU);
        tick();
        chk_outs("trap_jmp", O_TRAP);
        tick();
        irq_req = 0;
        chk_outs("run_after_trap", O_IDLE);
        check("perf_after_t3", perf_stall_cnt, 32'd10);

        // T4: drain with E/M1/M2 occupied
        e_valid = 1; m1_valid = 1; m2_valid = 1; irq_req = 1;
        chk_outs("t4_irq", O_LU);
        tick();
        e_valid = 0;
        chk_outs("t4_drain1", O_LU);
        tick();
        m1_valid = 0;
        chk_outs("t4_drain2", O_LU);
        tick();
        m2_valid = 0;
        chk_outs("t4_drain3", O_LU);
        tick();
        chk_outs("t4_trap", O_TRAP);
        tick();
        irq_req = 0;
        chk_outs("t4_run", O_IDLE);
        check("perf_after_t4", perf_stall_cnt, 32'd14);

        // T5: freeze during drain holds the state
        irq_req = 1;
        chk_outs("t5_irq", O_LU);
        tick();
        irq_req = 0; m2_valid = 1;
        chk_outs("t5_drain", O_LU);
        tick();
        m2_valid = 0; m1_mem_req = 1; dmem_ready = 0;
        chk_outs("t5_freeze", O_FRZ);
        tick();
        m1_mem_req = 0; dmem_ready = 1;
        chk_outs("t5_resume_drain", O_LU);
        tick();
        chk_outs("t5_trap", O_TRAP);
        tick();
        chk_outs("t5_run", O_IDLE);
        check("perf_after_t5", perf_stall_cnt, 32'd18);

        // T6: asynchronous reset in the middle of a drain
        irq_req = 1;
        tick();
        m2_valid = 1;
        chk_outs("t6_drain", O_LU);
        check("t6_perf_pre", perf_stall_cnt, 32'd19);
        nrst = 1'b0;
        chk_outs("t6_reset_outs", O_IDLE);
        check("t6_reset_perf", perf_stall_cnt, 32'd0);
        tick();
        m1_mem_req = 1; dmem_ready = 0;
        chk_outs("t6_reset_freeze_masked", O_IDLE);
        #2;
        clr();
        nrst = 1'b1;
        chk_outs("t6_released", O_IDLE);
        tick();
        chk_outs("t6_no_ack", O_IDLE);
        check("t6_perf_after", perf_stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
